clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Runtime-programmable integer clock divider with a configuration handshake and glitch-free ratio switching.
- Produces a divided clock `clk_out` and a one-cycle tick `clk_flag` for downstream logic.
- Sits between a config master (key or UART register) and the divided-clock consumers.
- Replaces fixed-ratio dividers wherever the ratio must change without reset.

Parameters:
- DIV_W, 8: width of divide-ratio field and counter.
- DEF_DIV, 6: ratio loaded at reset. Legal range 2..2^DIV_W-1.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- cfg_valid  input  1  new ratio offered on cfg_div.
- cfg_div  input  DIV_W  requested divide ratio N.
- cfg_ready  output  1  controller can accept a config this cycle.
- cfg_err  output  1  one-cycle pulse: the offered ratio was rejected (N<2).
- clk_out  output  1  divided clock; registered.
- clk_flag  output  1  one-cycle pulse per divided period; registered.
- busy  output  1  high in RUN, PEND, STOP.
- cur_div  output  DIV_W  ratio currently in effect.

Behaviour:
- Reset (async, sys_rst_n=0):
  - cnt=0, state=IDLE, cur_div=DEF_DIV, shadow cleared.
  - clk_out=0, clk_flag=0, cfg_err=0, cfg_ready=1, busy=0.
- Counting, with N=cur_div:
  - cnt runs 0..N-1 and wraps to 0.
  - clk_out=1 while cnt < N>>1, else 0. For N=6: 3 high, 3 low. For N=3: 1 high, 2 low.
  - clk_flag=1 in the cycle where cnt==N-1.
  - Both outputs are derived from next-state so they stay cycle-aligned with the registered cnt.
- Handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - If cfg_div<2: cfg_err pulses the next cycle, nothing changes, and the state is unaffected.
- FSM states: IDLE, RUN, PEND, STOP.
  - IDLE:
    - cnt=0, clk_out=0; cfg_ready=1.
    - A valid transfer loads cur_div immediately.
    - en=1 -> RUN. The first RUN cycle has cnt=0 and clk_out=1.
  - RUN:
    - cfg_ready=1.
    - A valid transfer stores the ratio in the shadow -> PEND.
    - en=0 -> STOP.
  - PEND:
    - cfg_ready=0.
    - At the wrap cycle (cnt==N-1): cur_div<=shadow and cnt<=0, so the new period starts on the next cycle. Then -> RUN, or -> IDLE if en=0.
    - No partial period is ever emitted.
  - STOP:
    - Completes the current period, then -> IDLE at the wrap cycle.
    - If en returns to 1 before the wrap -> RUN, with no discontinuity.
    - cfg_ready=1. A valid transfer goes to the shadow and is applied at the same wrap.
- Simultaneous events:
  - Transfer and wrap in the same RUN cycle: the new ratio takes effect at the next wrap, not the current one.
  - en=0 and transfer in the same RUN cycle: go to STOP, shadow loaded, applied at the wrap.
- clk_out is a fabric signal, not a global clock; consumers use clk_flag as an enable where possible.
- Width rules:
  - cnt is DIV_W bits.
  - N>>1 is a logical shift.
  - No overflow for N ≤ 2^DIV_W-1.
- Reset mid-operation returns everything to reset values immediately; the shadow is lost.

Decomposition:
- Package clk_div_pkg holds:
  - state encoding (IDLE, RUN, PEND, STOP as a 2-bit enum);
  - constant MIN_DIV=2.
- One sub-module, div_core: counter plus clk_out/clk_flag generation.
  - Inputs: run, cur_div.
  - Outputs: wrap, clk_out, clk_flag.
- The FSM and handshake live in clk_div_ctrl.

Test Plan:
- Reset, en=1, no config -> clk_out 3 high / 3 low. clk_flag pulses every 6 cycles. cur_div=6.
- In RUN at cnt=1, offer cfg_div=4 -> cfg_ready drops. The current 6-cycle period completes, then periods are 4 cycles (2 high / 2 low). cur_div=4 at the wrap.
- Offer cfg_div=1 and then 0 -> cfg_err pulses once each. cur_div, state and waveform are unchanged.
- en=0 at cnt=2 with N=6 -> the period finishes (cnt reaches 5, clk_flag pulses), then IDLE with clk_out=0. Repeat with en re-asserted at cnt=4 -> no gap in the output.
- Odd ratio cfg_div=5 from IDLE -> applied immediately. With en=1: 2 high / 3 low, clk_flag every 5 cycles.
- Assert sys_rst_n=0 while in PEND -> all outputs return to reset values at once. After release, ratio=6 and the shadowed value is discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the runtime-programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_ctrl_div_core.sv
// Divide-by-N counter producing a registered divided clock and period tick.
module div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] cur_div,
  output logic             wrap,
  output logic             clk_out,
  output logic             clk_flag
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] half;
  logic             active;

  assign last = cur_div - DIV_W'(1);
  assign half = cur_div >> 1;
  assign wrap = active && (cnt == last);

  // A period always starts at zero: the first active cycle and every wrap restart the count.
  always_comb begin
    cnt_next = '0;
    if (run && active && !wrap) begin
      cnt_next = cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      active   <= 1'b0;
      clk_out  <= 1'b0;
      clk_flag <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      active   <= run;
      clk_out  <= run && (cnt_next < half);
      clk_flag <= run && (cnt_next == last);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: config handshake, shadowed ratio updates applied only at period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             clk_flag,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] cur_div_next;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] shadow_next;
  logic             shadow_valid;
  logic             shadow_valid_next;
  logic             transfer;
  logic             good;
  logic             run;
  logic             wrap;

  assign cfg_ready = (state != PEND);
  assign busy      = (state != IDLE);
  assign transfer  = cfg_valid && cfg_ready;
  assign good      = transfer && (cfg_div >= MIN_N);
  assign run       = (state_next != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cur_div      <= DEF_N;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_next;
      cur_div      <= cur_div_next;
      shadow       <= shadow_next;
      shadow_valid <= shadow_valid_next;
      cfg_err      <= transfer && !good;
    end
  end

  // While counting, an accepted ratio waits in the shadow until the running period wraps.
  always_comb begin
    state_next        = state;
    cur_div_next      = cur_div;
    shadow_next       = shadow;
    shadow_valid_next = shadow_valid;
    case (state)
      IDLE: begin
        if (good) begin
          cur_div_next = cfg_div;
        end
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (good) begin
          shadow_next       = cfg_div;
          shadow_valid_next = 1'b1;
        end
        if (!en) begin
          state_next = (wrap && !good) ? IDLE : STOP;
        end else if (good) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          cur_div_next      = shadow;
          shadow_valid_next = 1'b0;
          state_next        = en ? RUN : IDLE;
        end
      end
      STOP: begin
        if (wrap) begin
          if (shadow_valid) begin
            cur_div_next      = shadow;
            shadow_valid_next = 1'b0;
          end
          if (good) begin
            shadow_next       = cfg_div;
            shadow_valid_next = 1'b1;
            state_next        = en ? PEND : STOP;
          end else begin
            state_next = en ? RUN : IDLE;
          end
        end else begin
          if (good) begin
            shadow_next       = cfg_div;
            shadow_valid_next = 1'b1;
          end
          if (en) begin
            state_next = (shadow_valid || good) ? PEND : RUN;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  div_core #(
    .DIV_W(DIV_W)
  ) u_div_core (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .run      (run),
    .cur_div  (cur_div),
    .wrap     (wrap),
    .clk_out  (clk_out),
    .clk_flag (clk_flag)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with hand-computed waveforms.
module tb_clk_div_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       clk_flag;
  logic       busy;
  logic [7:0] cur_div;

  int assert_count = 0;
  int fail_count   = 0;

  clk_div_ctrl #(
    .DIV_W   (8),
    .DEF_DIV (6)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .clk_flag  (clk_flag),
    .busy      (busy),
    .cur_div   (cur_div)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic valid_v, input logic [7:0] div_v);
    en        = en_v;
    cfg_valid = valid_v;
    cfg_div   = div_v;
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkStatus(input string tag, input logic ready_e, input logic busy_e,
                             input logic err_e, input logic [7:0] div_e);
    checkOutput({tag, "_ready"}, cfg_ready, ready_e);
    checkOutput({tag, "_busy"}, busy, busy_e);
    checkOutput({tag, "_err"}, cfg_err, err_e);
    checkOutput({tag, "_div"}, cur_div, div_e);
  endtask

  // Patterns are read MSB first, one bit per sampled cycle.
  task automatic checkPattern(input string tag, input int n, input logic [31:0] out_pat,
                              input logic [31:0] flag_pat);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      checkOutput($sformatf("%s_out[%0d]", tag, i), clk_out, out_pat[n-1-i]);
      checkOutput($sformatf("%s_flag[%0d]", tag, i), clk_flag, flag_pat[n-1-i]);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0);
    #12;
    checkStatus("reset", 1'b1, 1'b0, 1'b0, 8'd6);
    checkOutput("reset_out", clk_out, 1'b0);
    checkOutput("reset_flag", clk_flag, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("n6", 12, 32'b111000111000, 32'b000001000001);
    checkStatus("run6", 1'b1, 1'b1, 1'b0, 8'd6);

    // Ratio change offered mid-period at cnt=1.
    checkPattern("n6b", 2, 32'b11, 32'b00);
    applyStimulus(1'b1, 1'b1, 8'd4);
    stepCycle();
    checkStatus("pend4", 1'b0, 1'b1, 1'b0, 8'd6);
    checkOutput("pend4_out", clk_out, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("sw4", 11, 32'b00011001100, 32'b00100010001);
    checkStatus("run4", 1'b1, 1'b1, 1'b0, 8'd4);

    // Rejected ratios 1 and 0.
    applyStimulus(1'b1, 1'b1, 8'd1);
    stepCycle();
    checkStatus("err1", 1'b1, 1'b1, 1'b1, 8'd4);
    checkOutput("err1_out", clk_out, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    stepCycle();
    checkStatus("err1_clr", 1'b1, 1'b1, 1'b0, 8'd4);
    checkOutput("err1_clr_out", clk_out, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd0);
    stepCycle();
    checkStatus("err0", 1'b1, 1'b1, 1'b1, 8'd4);
    checkOutput("err0_out", clk_out, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    stepCycle();
    checkStatus("err0_clr", 1'b1, 1'b1, 1'b0, 8'd4);
    checkOutput("err0_clr_out", clk_out, 1'b0);
    checkOutput("err0_clr_flag", clk_flag, 1'b1);

    // Transfer on the wrap cycle applies at the following wrap.
    applyStimulus(1'b1, 1'b1, 8'd6);
    stepCycle();
    checkStatus("pend6", 1'b0, 1'b1, 1'b0, 8'd4);
    checkOutput("pend6_out", clk_out, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("sw6", 4, 32'b1001, 32'b0010);
    checkStatus("run6b", 1'b1, 1'b1, 1'b0, 8'd6);

    // Disable at cnt=2: period completes, then idle.
    checkPattern("pre_stop", 2, 32'b11, 32'b00);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkPattern("stop", 1, 32'b0, 32'b0);
    checkStatus("stopping", 1'b1, 1'b1, 1'b0, 8'd6);
    checkPattern("stop_tail", 4, 32'b0000, 32'b0100);
    checkStatus("idle", 1'b1, 1'b0, 1'b0, 8'd6);

    // Disable at cnt=2, re-enable at cnt=4: no gap.
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("restart", 3, 32'b111, 32'b000);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkPattern("dip", 2, 32'b00, 32'b00);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("resume", 7, 32'b0111000, 32'b1000001);
    checkStatus("resumed", 1'b1, 1'b1, 1'b0, 8'd6);

    // Wind down to idle, then load an odd ratio.
    checkPattern("n6c", 1, 32'b1, 32'b0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkPattern("wind", 6, 32'b110000, 32'b000010);
    checkStatus("idle2", 1'b1, 1'b0, 1'b0, 8'd6);
    applyStimulus(1'b0, 1'b1, 8'd5);
    stepCycle();
    checkStatus("load5", 1'b1, 1'b0, 1'b0, 8'd5);
    checkOutput("load5_out", clk_out, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("n5", 10, 32'b1100011000, 32'b0000100001);
    checkStatus("run5", 1'b1, 1'b1, 1'b0, 8'd5);

    // Reset while a ratio sits in the shadow.
    applyStimulus(1'b1, 1'b1, 8'd9);
    stepCycle();
    checkStatus("pend9", 1'b0, 1'b1, 1'b0, 8'd5);
    applyStimulus(1'b1, 1'b0, 8'd0);
    stepCycle();
    #2;
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0);
    #1;
    checkStatus("async_rst", 1'b1, 1'b0, 1'b0, 8'd6);
    checkOutput("async_rst_out", clk_out, 1'b0);
    checkOutput("async_rst_flag", clk_flag, 1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    stepCycle();
    checkStatus("post_rst", 1'b1, 1'b0, 1'b0, 8'd6);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkPattern("n6d", 7, 32'b1110001, 32'b0000010);
    checkStatus("final", 1'b1, 1'b1, 1'b0, 8'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
